// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the writeback/commit stage.
// Holds CSR numbering, op encodings, the interrupt ecode and the WB payload.
package wb_commit_stage_pkg;

    localparam int CSR_NUM_WIDTH = 14;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TID = 14'h40;
    localparam logic [5:0] ECODE_INT = 6'h0;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RD   = 2'b01,
        CSR_OP_WR   = 2'b10,
        CSR_OP_XCHG = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        RDCNT_NONE = 2'b00,
        RDCNT_VL   = 2'b01,
        RDCNT_VH   = 2'b10,
        RDCNT_ID   = 2'b11
    } rdcnt_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] vaddr;
        logic [4:0]  dest;
        logic        gr_we;
        csr_op_e     csr_op;
        logic [31:0] rj_value;
        logic [31:0] rkd_value;
        rdcnt_op_e   rdcnt_op;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        ertn;
    } ws_payload_t;

endpackage

// File: rtl/wb_commit_stage_stable_counter.sv
// 64-bit free-running stable counter, synchronous active-high reset.
// Ports: clk, reset in; cnt out (current count, wraps to 0).
module stable_counter (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] cnt
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: CSR access, exception/ertn/interrupt commit,
// flush + redirect, stable counter reads, GR writeback and debug trace.
// Ports: MEM handoff (ms_*), CSR port (csr_*), exception info (wb_*),
// flush/flush_target, GR write (rf_*), ws_csr_hazard, debug_wb_*.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int CSR_NUM_WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ms_to_ws_valid,
    output logic                     ws_allowin,
    input  logic [31:0]              ms_pc,
    input  logic [31:0]              ms_result,
    input  logic [31:0]              ms_vaddr,
    input  logic [4:0]               ms_dest,
    input  logic                     ms_gr_we,
    input  logic [1:0]               ms_csr_op,
    input  logic [CSR_NUM_WIDTH-1:0] ms_csr_num,
    input  logic [31:0]              ms_rj_value,
    input  logic [31:0]              ms_rkd_value,
    input  logic [1:0]               ms_rdcnt_op,
    input  logic                     ms_ex,
    input  logic [5:0]               ms_ecode,
    input  logic [8:0]               ms_esubcode,
    input  logic                     ms_ertn,
    output logic                     csr_re,
    output logic                     csr_we,
    output logic [CSR_NUM_WIDTH-1:0] csr_num,
    output logic [31:0]              csr_wmask,
    output logic [31:0]              csr_wvalue,
    input  logic [31:0]              csr_rvalue,
    output logic                     wb_ex_with_ertn,
    output logic                     ertn_flush,
    output logic [31:0]              wb_pc,
    output logic [31:0]              wb_vaddr,
    output logic [5:0]               wb_ecode,
    output logic [8:0]               wb_esubcode,
    input  logic                     has_int,
    input  logic [31:0]              ex_entry,
    output logic                     flush,
    output logic [31:0]              flush_target,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     ws_csr_hazard,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_we,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata
);

    logic                     ws_valid_q;
    logic                     ws_valid_d;
    ws_payload_t              ws_q;
    ws_payload_t              ws_d;
    logic [CSR_NUM_WIDTH-1:0] ws_csr_num_q;
    logic [CSR_NUM_WIDTH-1:0] ws_csr_num_d;

    logic        ws_ready_go;
    logic        ws_load;
    logic        ws_int;
    logic        ws_exc;
    logic [63:0] stable_cnt;

    stable_counter u_stable_counter (
        .clk   (clk),
        .reset (reset),
        .cnt   (stable_cnt)
    );

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = ~ws_valid_q | ws_ready_go;
    assign ws_load     = ms_to_ws_valid & ws_allowin;

    always_comb begin
        ws_d         = ws_q;
        ws_csr_num_d = ws_csr_num_q;
        if (ws_load) begin
            ws_d.pc        = ms_pc;
            ws_d.result    = ms_result;
            ws_d.vaddr     = ms_vaddr;
            ws_d.dest      = ms_dest;
            ws_d.gr_we     = ms_gr_we;
            ws_d.csr_op    = csr_op_e'(ms_csr_op);
            ws_d.rj_value  = ms_rj_value;
            ws_d.rkd_value = ms_rkd_value;
            ws_d.rdcnt_op  = rdcnt_op_e'(ms_rdcnt_op);
            ws_d.ex        = ms_ex;
            ws_d.ecode     = ms_ecode;
            ws_d.esubcode  = ms_esubcode;
            ws_d.ertn      = ms_ertn;
            ws_csr_num_d   = ms_csr_num;
        end
    end

    // A flush kills the committing instruction and whatever MEM hands
    // over on the same edge, since that instruction is on the wrong path.
    always_comb begin
        ws_valid_d = ws_valid_q;
        if (flush) begin
            ws_valid_d = 1'b0;
        end else if (ws_allowin) begin
            ws_valid_d = ms_to_ws_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q   <= 1'b0;
            ws_q         <= '0;
            ws_csr_num_q <= '0;
        end else begin
            ws_valid_q   <= ws_valid_d;
            ws_q         <= ws_d;
            ws_csr_num_q <= ws_csr_num_d;
        end
    end

    // Interrupt outranks an upstream exception, which outranks ertn.
    assign ws_int     = ws_valid_q & has_int;
    assign ws_exc     = ws_valid_q & (ws_int | ws_q.ex);
    assign ertn_flush = ws_valid_q & ws_q.ertn & ~ws_int & ~ws_q.ex;

    assign wb_ex_with_ertn = ws_exc | (ws_valid_q & ws_q.ertn);
    assign wb_ecode        = ws_int ? ECODE_INT : ws_q.ecode;
    assign wb_esubcode     = ws_int ? 9'd0 : ws_q.esubcode;
    assign wb_pc           = ws_q.pc;
    assign wb_vaddr        = ws_q.vaddr;

    assign flush        = ws_exc | ertn_flush;
    assign flush_target = ex_entry;

    assign csr_re = ws_valid_q
                  & ((ws_q.csr_op != CSR_OP_NONE)
                   | (ws_q.rdcnt_op == RDCNT_ID));
    assign csr_we = ws_valid_q & ws_q.csr_op[1] & ~ws_exc;

    assign csr_num = (ws_q.rdcnt_op == RDCNT_ID)
                   ? CSR_NUM_WIDTH'(CSR_TID) : ws_csr_num_q;

    always_comb begin
        csr_wmask = 32'h0;
        unique case (ws_q.csr_op)
            CSR_OP_XCHG: csr_wmask = ws_q.rj_value;
            CSR_OP_WR:   csr_wmask = 32'hFFFF_FFFF;
            default:     csr_wmask = 32'h0;
        endcase
    end

    assign csr_wvalue = ws_q.rkd_value;

    // CSR instructions return the value read before this edge's write.
    always_comb begin
        rf_wdata = ws_q.result;
        if (ws_q.csr_op != CSR_OP_NONE) begin
            rf_wdata = csr_rvalue;
        end else begin
            unique case (ws_q.rdcnt_op)
                RDCNT_VL: rf_wdata = stable_cnt[31:0];
                RDCNT_VH: rf_wdata = stable_cnt[63:32];
                RDCNT_ID: rf_wdata = csr_rvalue;
                default:  rf_wdata = ws_q.result;
            endcase
        end
    end

    assign rf_we    = ws_valid_q & ws_q.gr_we & ~ws_exc & ~ertn_flush;
    assign rf_waddr = ws_q.dest;

    assign ws_csr_hazard = (ws_valid_q & (ws_q.csr_op[1] | ws_q.ertn))
                         | ws_exc;

    assign debug_wb_pc       = ws_q.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed self-checking bench for wb_commit_stage.
// Linear steps; immediate assertions at every comparison point.
module tb_wb_commit_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc, ms_result, ms_vaddr;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic [1:0]  ms_csr_op;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_rj_value, ms_rkd_value;
    logic [1:0]  ms_rdcnt_op;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic [8:0]  ms_esubcode;
    logic        ms_ertn;
    logic        csr_re, csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue, csr_rvalue;
    logic        wb_ex_with_ertn, ertn_flush;
    logic [31:0] wb_pc, wb_vaddr;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        has_int;
    logic [31:0] ex_entry;
    logic        flush;
    logic [31:0] flush_target;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_csr_hazard;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] cyc;

    always #5 clk = ~clk;

    // Reference count of edges since reset released.
    always @(posedge clk) begin
        if (reset) cyc <= 64'd0;
        else       cyc <= cyc + 64'd1;
    end

    wb_commit_stage #(.CSR_NUM_WIDTH(14)) dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allowin        (ws_allowin),
        .ms_pc             (ms_pc),
        .ms_result         (ms_result),
        .ms_vaddr          (ms_vaddr),
        .ms_dest           (ms_dest),
        .ms_gr_we          (ms_gr_we),
        .ms_csr_op         (ms_csr_op),
        .ms_csr_num        (ms_csr_num),
        .ms_rj_value       (ms_rj_value),
        .ms_rkd_value      (ms_rkd_value),
        .ms_rdcnt_op       (ms_rdcnt_op),
        .ms_ex             (ms_ex),
        .ms_ecode          (ms_ecode),
        .ms_esubcode       (ms_esubcode),
        .ms_ertn           (ms_ertn),
        .csr_re            (csr_re),
        .csr_we            (csr_we),
        .csr_num           (csr_num),
        .csr_wmask         (csr_wmask),
        .csr_wvalue        (csr_wvalue),
        .csr_rvalue        (csr_rvalue),
        .wb_ex_with_ertn   (wb_ex_with_ertn),
        .ertn_flush        (ertn_flush),
        .wb_pc             (wb_pc),
        .wb_vaddr          (wb_vaddr),
        .wb_ecode          (wb_ecode),
        .wb_esubcode       (wb_esubcode),
        .has_int           (has_int),
        .ex_entry          (ex_entry),
        .flush             (flush),
        .flush_target      (flush_target),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_csr_hazard     (ws_csr_hazard),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_ms();
        ms_to_ws_valid = 1'b0;
        ms_pc = 32'h0; ms_result = 32'h0; ms_vaddr = 32'h0;
        ms_dest = 5'd0; ms_gr_we = 1'b0;
        ms_csr_op = 2'b00; ms_csr_num = 14'h0;
        ms_rj_value = 32'h0; ms_rkd_value = 32'h0;
        ms_rdcnt_op = 2'b00;
        ms_ex = 1'b0; ms_ecode = 6'h0; ms_esubcode = 9'h0;
        ms_ertn = 1'b0;
    endtask

    // Hand the prepared ms_* fields over; return #1 after the load edge.
    task automatic push();
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clr_ms();
        csr_rvalue = 32'h0;
        has_int = 1'b0;
        ex_entry = 32'h1C00_8000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_flush", flush, 0);
        chk("rst_csr_re", csr_re, 0);
        chk("rst_csr_we", csr_we, 0);
        chk("rst_ertn", ertn_flush, 0);
        chk("rst_exwe", wb_ex_with_ertn, 0);
        chk("rst_hazard", ws_csr_hazard, 0);
        chk("rst_allowin", ws_allowin, 1);
        @(negedge clk);
        reset = 1'b0;

        // csrwr
        clr_ms();
        ms_csr_op = 2'b10; ms_csr_num = 14'h30;
        ms_rkd_value = 32'hDEAD_BEEF; ms_gr_we = 1'b1; ms_dest = 5'd5;
        ms_pc = 32'h1C00_0010;
        csr_rvalue = 32'h11;
        push();
        chk("wr_csr_we", csr_we, 1);
        chk("wr_csr_re", csr_re, 1);
        chk("wr_num", csr_num, 14'h30);
        chk("wr_wmask", csr_wmask, 32'hFFFF_FFFF);
        chk("wr_wvalue", csr_wvalue, 32'hDEAD_BEEF);
        chk("wr_wdata", rf_wdata, 32'h11);
        chk("wr_rf_we", rf_we, 1);
        chk("wr_waddr", rf_waddr, 5);
        chk("wr_dbg_we", debug_wb_rf_we, 4'hF);
        chk("wr_dbg_pc", debug_wb_pc, 32'h1C00_0010);
        chk("wr_hazard", ws_csr_hazard, 1);
        chk("wr_flush", flush, 0);

        // csrxchg
        clr_ms();
        ms_csr_op = 2'b11; ms_csr_num = 14'h6;
        ms_rj_value = 32'h0000_FF00; ms_rkd_value = 32'h1234_5678;
        ms_gr_we = 1'b1; ms_dest = 5'd7;
        csr_rvalue = 32'hA5A5_0000;
        push();
        chk("xchg_wmask", csr_wmask, 32'h0000_FF00);
        chk("xchg_wvalue", csr_wvalue, 32'h1234_5678);
        chk("xchg_rf_we", rf_we, 1);
        chk("xchg_wdata", rf_wdata, 32'hA5A5_0000);
        chk("xchg_we", csr_we, 1);

        // upstream exception, then an instruction on the flush edge
        clr_ms();
        ms_ex = 1'b1; ms_ecode = 6'h8; ms_esubcode = 9'd1;
        ms_pc = 32'h1C00_0100; ms_vaddr = 32'h0000_0055;
        ms_gr_we = 1'b1; ms_dest = 5'd3;
        push();
        chk("ex_exwe", wb_ex_with_ertn, 1);
        chk("ex_flush", flush, 1);
        chk("ex_target", flush_target, 32'h1C00_8000);
        chk("ex_rf_we", rf_we, 0);
        chk("ex_ecode", wb_ecode, 6'h8);
        chk("ex_esub", wb_esubcode, 9'd1);
        chk("ex_pc", wb_pc, 32'h1C00_0100);
        chk("ex_vaddr", wb_vaddr, 32'h55);
        chk("ex_ertn", ertn_flush, 0);
        clr_ms();
        ms_gr_we = 1'b1; ms_dest = 5'd9; ms_result = 32'hAA;
        push();
        chk("drop_flush", flush, 0);
        chk("drop_rf_we", rf_we, 0);
        chk("drop_csr_re", csr_re, 0);

        // ertn
        clr_ms();
        ms_ertn = 1'b1; ex_entry = 32'h1C00_0200;
        push();
        chk("ertn_flush", ertn_flush, 1);
        chk("ertn_f", flush, 1);
        chk("ertn_target", flush_target, 32'h1C00_0200);
        chk("ertn_exwe", wb_ex_with_ertn, 1);
        idle();
        chk("ertn_once", flush, 0);

        // ertn with a pending interrupt
        clr_ms();
        ms_ertn = 1'b1; ms_ecode = 6'h3;
        has_int = 1'b1;
        push();
        chk("int_ertn", ertn_flush, 0);
        chk("int_flush", flush, 1);
        chk("int_ecode", wb_ecode, 6'h0);
        chk("int_exwe", wb_ex_with_ertn, 1);
        idle();
        chk("int_empty", flush, 0);
        has_int = 1'b0;

        // exception and ertn together
        clr_ms();
        ms_ertn = 1'b1; ms_ex = 1'b1; ms_ecode = 6'hB; ms_esubcode = 9'd4;
        push();
        chk("exertn_ertn", ertn_flush, 0);
        chk("exertn_flush", flush, 1);
        chk("exertn_ecode", wb_ecode, 6'hB);
        chk("exertn_esub", wb_esubcode, 9'd4);
        idle();

        // csrwr with interrupt: write suppressed
        clr_ms();
        ms_csr_op = 2'b10; ms_csr_num = 14'h30; ms_gr_we = 1'b1;
        ms_rkd_value = 32'h1;
        has_int = 1'b1;
        push();
        chk("intwr_csr_we", csr_we, 0);
        chk("intwr_rf_we", rf_we, 0);
        chk("intwr_flush", flush, 1);
        idle();
        has_int = 1'b0;

        // rdcntvl / rdcntvh
        clr_ms();
        ms_rdcnt_op = 2'b01; ms_gr_we = 1'b1; ms_dest = 5'd4;
        push();
        chk("cntvl_wdata", rf_wdata, cyc[31:0]);
        chk("cntvl_rf_we", rf_we, 1);
        chk("cntvl_re", csr_re, 0);
        clr_ms();
        ms_rdcnt_op = 2'b10; ms_gr_we = 1'b1;
        push();
        chk("cntvh_wdata", rf_wdata, 32'h0);

        // rdcntid
        clr_ms();
        ms_rdcnt_op = 2'b11; ms_gr_we = 1'b1; ms_csr_num = 14'h5;
        csr_rvalue = 32'h1234_5678;
        push();
        chk("tid_re", csr_re, 1);
        chk("tid_num", csr_num, 14'h40);
        chk("tid_wdata", rf_wdata, 32'h1234_5678);
        chk("tid_we", csr_we, 0);

        // plain ALU result
        clr_ms();
        ms_result = 32'h0000_CAFE; ms_gr_we = 1'b1; ms_dest = 5'd31;
        push();
        chk("alu_wdata", rf_wdata, 32'h0000_CAFE);
        chk("alu_waddr", debug_wb_rf_wnum, 5'd31);
        chk("alu_hazard", ws_csr_hazard, 0);
        idle();
        chk("idle_rf_we", rf_we, 0);

        // reset during a flush cycle
        clr_ms();
        ms_ex = 1'b1;
        push();
        chk("rstf_flush", flush, 1);
        @(negedge clk);
        reset = 1'b1;
        ms_ex = 1'b0; ms_gr_we = 1'b1;
        ms_to_ws_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rstf_flush0", flush, 0);
        chk("rstf_rf_we", rf_we, 0);
        chk("rstf_cnt", cyc, 0);
        @(negedge clk);
        reset = 1'b0;
        ms_to_ws_valid = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_stage.md
# wb_commit_stage

Writeback/commit stage of the five-stage LoongArch core, directly upstream of `CSR_module`. It latches the MEM-stage result and performs CSR read/write/exchange through the CSR port. It also tags pending interrupts onto the committing instruction, raises exceptions and `ertn`, and generates the pipeline flush and redirect target. It further owns the 64-bit stable counter for `rdcntvl.w`/`rdcntvh.w`/`rdcntid`, and drives register-file writeback plus the debug trace.

## Interface
Parameters:
- `CSR_NUM_WIDTH`, 14, CSR number width (matches `CSR_module`).

Ports: one clock; reset is synchronous and active-high.
- `clk` in 1: core clock.
- `reset` in 1: synchronous active-high reset.
- `ms_to_ws_valid` in 1: MEM holds a valid instruction.
- `ws_allowin` out 1: WB accepts a new instruction this edge.
- `ms_pc`, `ms_result`, `ms_vaddr` in 32 each: PC, ALU/load result, faulting data address.
- `ms_dest` in 5, `ms_gr_we` in 1: GR destination and write enable.
- `ms_csr_op` in 2: 00 none, 01 csrrd, 10 csrwr, 11 csrxchg.
- `ms_csr_num` in CSR_NUM_WIDTH: CSR number.
- `ms_rj_value`, `ms_rkd_value` in 32 each: xchg mask, write data.
- `ms_rdcnt_op` in 2: 00 none, 01 rdcntvl.w, 10 rdcntvh.w, 11 rdcntid.
- `ms_ex` in 1, `ms_ecode` in 6, `ms_esubcode` in 9: upstream-detected exception.
- `ms_ertn` in 1: instruction is `ertn`.
- `csr_re`, `csr_we` out 1; `csr_num` out CSR_NUM_WIDTH; `csr_wmask`, `csr_wvalue` out 32: CSR access port.
- `csr_rvalue` in 32: CSR read data, combinational.
- `wb_ex_with_ertn`, `ertn_flush` out 1: CSR exception/ertn strobes.
- `wb_pc`, `wb_vaddr` out 32; `wb_ecode` out 6; `wb_esubcode` out 9: exception info.
- `has_int` in 1, `ex_entry` in 32: from CSR.
- `flush` out 1, `flush_target` out 32: pipeline kill and IF redirect.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32: GR write port.
- `ws_csr_hazard` out 1: valid WB instruction writes a CSR or is ertn/exception; decode stalls CSR reads.
- `debug_wb_pc` out 32, `debug_wb_rf_we` out 4, `debug_wb_rf_wnum` out 5, `debug_wb_rf_wdata` out 32: trace.

## Operation
- Pipeline register `ws_valid` plus payload.
  - `ws_allowin = ~ws_valid | ws_ready_go`, with `ws_ready_go = 1`.
  - Payload loads when `ms_to_ws_valid & ws_allowin`.
- Interrupt tag: `ws_int = ws_valid & has_int`. Priority is interrupt > `ms_ex` > ertn.
- `ws_exc = ws_valid & (ws_int | ws_ex)`.
  - `wb_ecode`/`wb_esubcode` = 0x0/0 when `ws_int`, else latched codes.
- `wb_ex_with_ertn = ws_exc | (ws_valid & ws_ertn)`.
- `ertn_flush = ws_valid & ws_ertn & ~ws_int & ~ws_ex`.
- `wb_pc = ws_pc`, `wb_vaddr = ws_vaddr`.
- CSR access:
  - `csr_re = ws_valid & (csr_op != 0 | rdcnt_op == 11)`.
  - `csr_num` = 0x40 (TID) when rdcntid, else `ws_csr_num`.
  - `csr_we = ws_valid & csr_op[1] & ~ws_exc`.
  - `csr_wmask` = `rj_value` for xchg, all-ones for csrwr.
  - `csr_wvalue = rkd_value`.
- `rf_wdata` selection:
  - csr op: `csr_rvalue` (pre-write value).
  - rdcntvl: `stable_cnt[31:0]`.
  - rdcntvh: `stable_cnt[63:32]`.
  - rdcntid: `csr_rvalue`.
  - otherwise `ws_result`.
- `rf_we = ws_valid & ws_gr_we & ~ws_exc & ~ertn_flush`. `rf_waddr = ws_dest`.
- `flush = ws_exc | ertn_flush`. `flush_target = ex_entry` (CSR selects ERA for ertn, EENTRY otherwise).
- Stable counter `stable_cnt` (64 bits): resets to 0, increments every cycle, wraps from all-ones to 0. It is never written or stalled.
- Debug: `debug_wb_rf_we = {4{rf_we}}`; the other trace signals mirror the rf/pc outputs.

## Timing
- Reset: `ws_valid=0`, `stable_cnt=0`. All strobes (`csr_re/we`, `flush`, `rf_we`, `ertn_flush`, `wb_ex_with_ertn`, `ws_csr_hazard`) are 0. Payload registers are don't-care but must not cause X on strobes.
- Latency: one cycle from MEM handoff to commit. Commit actions are combinational within the WB cycle; CSR state updates at the following edge.
- Flush cycle: the next edge clears `ws_valid`. Any `ms_to_ws_valid` arriving on that edge is discarded (wrong path). Flush is asserted for exactly one cycle per event.
- `has_int` is sampled only while `ws_valid=1`. An interrupt with an empty WB waits for the next valid instruction.
- Simultaneous `ms_ex` and `ms_ertn`: exception wins and `ertn_flush=0`.
- Simultaneous `csr_we` with `has_int`: write suppressed.
- rdcntvl in the same cycle the counter wraps: returns the pre-increment value.
- Reset mid-flush: reset dominates and `ws_valid=0` at the next edge.

## Structure
- Shared package/header (`constants.h`) holds:
  - `CSR_NUM_WIDTH`, `CSR_TID` (0x40).
  - CSR-op and rdcnt-op encodings.
  - `ECODE_INT` (0x0).
- Sub-module `stable_counter`: 64-bit free-running counter with synchronous reset.

## Test plan
- csrwr: `csr_num=0x30`, rkd=0xDEADBEEF, CSR returns 0x11 → `csr_we=1`, `wmask=0xFFFFFFFF`, `rf_wdata=0x11`.
- csrxchg: rj=0x0000FF00, rkd=0x12345678 → `wmask=0x0000FF00`, `wvalue=0x12345678`, `rf_we=1`.
- `ms_ex` (ecode 0x8, esubcode 1, pc 0x1C000100) → `wb_ex_with_ertn=1`, `flush=1` for one cycle, `flush_target=ex_entry`, `rf_we=0`. An instruction arriving the next edge is dropped.
- ertn with `ex_entry=0x1C000200` → `ertn_flush=1`, `flush_target=0x1C000200`. With `has_int=1` instead: ecode 0, `ertn_flush=0`.
- rdcntvl/rdcntvh 10 cycles after reset → `rf_wdata` = counter value/0. Force `stable_cnt=0xFFFFFFFF` → next cycle vh reads 1.
- rdcntid → `csr_re=1`, `csr_num=0x40`, `rf_wdata=0x12345678`.
